// File: rtl/nibble_counter.sv
// Prescaled 16-bit up/down counter exposing four hex digits,
// step/wrap pulses and a leading-zero blanking mask.
module nibble_counter #(
  parameter int unsigned DIV = 50000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        UP,
  input  logic        CLR,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VAL,
  output logic [3:0]  DIG0,
  output logic [3:0]  DIG1,
  output logic [3:0]  DIG2,
  output logic [3:0]  DIG3,
  output logic        TICK,
  output logic        WRAP,
  output logic [3:0]  BLANK
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [15:0]   value;
  logic          pre_end;
  logic          step;
  logic          edge_val;

  assign pre_end  = (pre == LAST);
  assign step     = EN && pre_end && !CLR && !LOAD;
  // value about to roll over in the current direction
  assign edge_val = UP ? (value == 16'hFFFF) : (value == 16'h0000);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      value <= '0;
      pre   <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else if (CLR) begin
      value <= '0;
      pre   <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else if (LOAD) begin
      value <= LOAD_VAL;
      pre   <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else begin
      TICK <= step;
      WRAP <= step && edge_val;
      if (EN) begin
        pre <= pre_end ? '0 : pre + PW'(1);
      end
      if (step) begin
        value <= UP ? value + 16'd1 : value - 16'd1;
      end
    end
  end

  assign DIG0 = value[3:0];
  assign DIG1 = value[7:4];
  assign DIG2 = value[11:8];
  assign DIG3 = value[15:12];

  assign BLANK[3] = (DIG3 == 4'd0);
  assign BLANK[2] = BLANK[3] && (DIG2 == 4'd0);
  assign BLANK[1] = BLANK[2] && (DIG1 == 4'd0);
  assign BLANK[0] = 1'b0;

endmodule

// File: tb/tb_nibble_counter.sv
// Directed plus random bench for nibble_counter with DIV=4,
// checked against an arithmetic reference model.
module tb_nibble_counter;

  localparam int DIV = 4;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        UP;
  logic        CLR;
  logic        LOAD;
  logic [15:0] LOAD_VAL;
  logic [3:0]  DIG0, DIG1, DIG2, DIG3;
  logic        TICK;
  logic        WRAP;
  logic [3:0]  BLANK;

  int vectors = 0;
  int miscompares = 0;

  int m_val;
  int m_ph;
  int m_tick;
  int m_wrap;

  nibble_counter #(.DIV(DIV)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .EN(EN),
    .UP(UP),
    .CLR(CLR),
    .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL),
    .DIG0(DIG0),
    .DIG1(DIG1),
    .DIG2(DIG2),
    .DIG3(DIG3),
    .TICK(TICK),
    .WRAP(WRAP),
    .BLANK(BLANK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] shown();
    return {DIG3, DIG2, DIG1, DIG0};
  endfunction

  function automatic logic [3:0] blank_of(input int v);
    if (v < 16)        return 4'b1110;
    else if (v < 256)  return 4'b1100;
    else if (v < 4096) return 4'b1000;
    else               return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_val"}, shown(), 16'(m_val));
    chk({tag, "_tick"}, {15'd0, TICK}, 16'(m_tick));
    chk({tag, "_wrap"}, {15'd0, WRAP}, 16'(m_wrap));
    chk({tag, "_blank"}, {12'd0, BLANK}, {12'd0, blank_of(m_val)});
  endtask

  task automatic model_reset();
    m_val = 0;
    m_ph = 0;
    m_tick = 0;
    m_wrap = 0;
  endtask

  // One rising edge of the counter expressed as plain arithmetic.
  task automatic model_edge();
    int nxt;
    m_tick = 0;
    m_wrap = 0;
    if (CLR) begin
      m_val = 0;
      m_ph = 0;
    end else if (LOAD) begin
      m_val = int'(LOAD_VAL);
      m_ph = 0;
    end else if (EN) begin
      m_ph++;
      if (m_ph == DIV) begin
        m_ph = 0;
        nxt = UP ? m_val + 1 : m_val - 1;
        m_wrap = (nxt < 0 || nxt > 65535) ? 1 : 0;
        m_val = (nxt + 65536) % 65536;
        m_tick = 1;
      end
    end
  endtask

  task automatic cyc(input logic en, input logic up, input logic clr,
                     input logic ld, input logic [15:0] ldv,
                     input string tag);
    EN = en;
    UP = up;
    CLR = clr;
    LOAD = ld;
    LOAD_VAL = ldv;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int first_tick;
    int ticks;
    int wraps;

    EN = 0;
    UP = 1;
    CLR = 0;
    LOAD = 0;
    LOAD_VAL = '0;
    RST_N = 0;
    model_reset();
    #1;
    check_all("reset_async");
    @(posedge CLK);
    #1;
    check_all("reset_hold");
    RST_N = 1;

    // count up from reset: first tick on the 4th enabled edge
    first_tick = -1;
    wraps = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 1, 0, 0, 16'h0, "up4");
      if (TICK && first_tick < 0) first_tick = i;
      if (WRAP) wraps++;
    end
    chk("first_tick_cycle", 16'(first_tick), 16'd4);
    chk("up4_value", shown(), 16'h0004);
    chk("up4_no_wrap", 16'(wraps), 16'd0);

    // wrap upward through FFFF
    cyc(1, 1, 0, 1, 16'hFFFE, "load_fffe");
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 16'h0, "wrap_up");
      if (WRAP) begin
        wraps++;
        chk("wrap_up_at_zero", shown(), 16'h0000);
      end
    end
    chk("wrap_up_count", 16'(wraps), 16'd1);
    chk("wrap_up_value", shown(), 16'h0000);

    // wrap downward from 0000
    cyc(1, 0, 1, 0, 16'h0, "clr");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 16'h0, "wrap_dn");
    chk("wrap_dn_value", shown(), 16'hFFFF);
    chk("wrap_dn_tick", {15'd0, TICK}, 16'd1);
    chk("wrap_dn_wrap", {15'd0, WRAP}, 16'd1);
    cyc(1, 0, 0, 0, 16'h0, "wrap_dn_after");
    chk("wrap_dn_pulse_end", {14'd0, TICK, WRAP}, 16'd0);

    // load coinciding with a step edge discards the step
    cyc(1, 1, 1, 0, 16'h0, "clr2");
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 16'h0, "pre_load");
    cyc(1, 1, 0, 1, 16'h1234, "load_on_step");
    chk("load_on_step_val", shown(), 16'h1234);
    chk("load_on_step_pulse", {14'd0, TICK, WRAP}, 16'd0);
    ticks = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 1, 0, 0, 16'h0, "after_load");
      if (TICK) ticks = i;
    end
    chk("after_load_tick_at4", 16'(ticks), 16'd4);
    chk("after_load_val", shown(), 16'h1235);
    cyc(1, 1, 1, 1, 16'hBEEF, "clr_and_load");
    chk("clr_beats_load", shown(), 16'h0000);

    // leading-zero blanking
    cyc(0, 1, 0, 1, 16'h0000, "bl0");
    chk("blank_0000", {12'd0, BLANK}, 16'b1110);
    cyc(0, 1, 0, 1, 16'h00A0, "bl1");
    chk("blank_00a0", {12'd0, BLANK}, 16'b1100);
    cyc(0, 1, 0, 1, 16'h0F00, "bl2");
    chk("blank_0f00", {12'd0, BLANK}, 16'b1000);
    cyc(0, 1, 0, 1, 16'h1000, "bl3");
    chk("blank_1000", {12'd0, BLANK}, 16'b0000);

    // asynchronous reset between clock edges
    cyc(1, 1, 0, 1, 16'h0FFE, "pre_rst_load");
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 16'h0, "pre_rst");
    #2;
    RST_N = 0;
    model_reset();
    #1;
    chk("async_rst_val", shown(), 16'h0000);
    chk("async_rst_pulse", {14'd0, TICK, WRAP}, 16'd0);
    chk("async_rst_blank", {12'd0, BLANK}, 16'b1110);
    @(posedge CLK);
    #1;
    RST_N = 1;

    // EN low freezes everything
    cyc(0, 1, 0, 1, 16'h5A5A, "freeze_load");
    cyc(1, 1, 0, 0, 16'h0, "freeze_pre");
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, ($urandom_range(0, 1) == 1), 0, 0, 16'h0, "freeze");
      if (TICK) ticks++;
    end
    chk("freeze_ticks", 16'(ticks), 16'd0);
    chk("freeze_val", shown(), 16'h5A5A);

    // randomized traffic, loads biased toward wrap boundaries
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ldv;
      case ($urandom_range(0, 3))
        0: ldv = 16'hFFFF - 16'($urandom_range(0, 2));
        1: ldv = 16'($urandom_range(0, 2));
        default: ldv = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) < 5),
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 25) == 0),
          ldv, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
